// File: rtl/pwl_seg_select_if.sv
// pwl_seg_select_if: request/response bundle for the PWL segment selector.
// Master side writes the breakpoint table and issues queries.
// Slave side returns the selected segment endpoints for the lerp stage.
interface pwl_seg_select_if #(
    parameter int S     = 32,
    parameter int N_PTS = 16
);
    localparam int AW = $clog2(N_PTS);

    // table write port
    logic          tab_we;
    logic [AW-1:0] tab_addr;
    logic [S-1:0]  tab_x;
    logic [S-1:0]  tab_y;

    // query request
    logic          start;
    logic [S-1:0]  x;

    // segment result
    logic [S-1:0]  x1;
    logic [S-1:0]  x2;
    logic [S-1:0]  y1;
    logic [S-1:0]  y2;
    logic [S-1:0]  x_out;
    logic          out_valid;
    logic          busy;
    logic          nan;

    modport master (
        output tab_we, tab_addr, tab_x, tab_y, start, x,
        input  x1, x2, y1, y2, x_out, out_valid, busy, nan
    );

    modport slave (
        input  tab_we, tab_addr, tab_x, tab_y, start, x,
        output x1, x2, y1, y2, x_out, out_valid, busy, nan
    );
endinterface

// File: rtl/pwl_seg_select.sv
// pwl_seg_select: piecewise-linear segment finder in front of a lerp stage.
// Holds an N_PTS-entry breakpoint table (ascending x), latches a query on
// start, and walks the table one breakpoint per cycle until the query falls
// below the next breakpoint (or the last segment is reached). The chosen
// segment endpoints and the value to evaluate are presented with a one-cycle
// out_valid pulse and held until the next accepted query.
// Build option: define PWL_CLAMP_EN to clamp x_out to the table range;
// without it x_out is the raw query and the end segments extrapolate.
module pwl_seg_select #(
    parameter int S     = 32,
    parameter int N_PTS = 16
) (
    input logic             clk,
    input logic             rst,
    pwl_seg_select_if.slave bus
);
    localparam int            AW     = $clog2(N_PTS);
    localparam logic [AW-1:0] K_LAST = AW'(N_PTS - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    // IEEE single to a signed key whose integer order is the float order;
    // -0 and +0 both map to zero so they compare equal.
    function automatic logic signed [S:0] f_key(input logic [S-1:0] f);
        logic signed [S:0] mag;
        mag = $signed({2'b00, f[S-2:0]});
        return f[S-1] ? -mag : mag;
    endfunction

    function automatic logic f_is_nan(input logic [S-1:0] f);
        return (&f[S-2:S-9]) && (|f[S-10:0]);
    endfunction

    logic [S-1:0]  r_tab_x [N_PTS];
    logic [S-1:0]  r_tab_y [N_PTS];

    state_t        r_state;
    logic [AW-1:0] r_k;
    logic [S-1:0]  r_q;
    logic          r_q_nan;

    logic [S-1:0]  r_x1;
    logic [S-1:0]  r_x2;
    logic [S-1:0]  r_y1;
    logic [S-1:0]  r_y2;
    logic [S-1:0]  r_x_out;
    logic          r_out_valid;
    logic          r_busy;
    logic          r_nan;

    logic [AW-1:0] w_k_next;
    logic [S-1:0]  w_x_next;
    logic          w_hit;
    logic          w_last;
    logic [S-1:0]  w_x_out;

    assign w_k_next = r_k + AW'(1);
    assign w_x_next = r_tab_x[w_k_next];
    assign w_hit    = f_key(r_q) < f_key(w_x_next);
    assign w_last   = (r_k == K_LAST);

    // Value handed to the lerp stage; optionally pinned to the table ends.
    always_comb begin
        w_x_out = r_q;
`ifdef PWL_CLAMP_EN
        if (f_key(r_q) < f_key(r_tab_x[0])) begin
            w_x_out = r_tab_x[0];
        end else if (f_key(r_q) > f_key(r_tab_x[N_PTS-1])) begin
            w_x_out = r_tab_x[N_PTS-1];
        end
`endif
    end

    // Table write port: only open while idle, and deliberately not reset so
    // a loaded table survives an abort.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && bus.tab_we && int'(bus.tab_addr) < N_PTS) begin
            r_tab_x[bus.tab_addr] <= bus.tab_x;
            r_tab_y[bus.tab_addr] <= bus.tab_y;
        end
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_q         <= '0;
            r_q_nan     <= 1'b0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
            r_x_out     <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_nan       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_out_valid <= 1'b0;
                    if (bus.start) begin
                        r_q     <= bus.x;
                        r_q_nan <= f_is_nan(bus.x);
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (r_q_nan) begin
                        // NaN has no segment: report it with zeroed data.
                        r_x1        <= '0;
                        r_x2        <= '0;
                        r_y1        <= '0;
                        r_y2        <= '0;
                        r_x_out     <= '0;
                        r_nan       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end else if (w_hit || w_last) begin
                        r_x1        <= r_tab_x[r_k];
                        r_x2        <= w_x_next;
                        r_y1        <= r_tab_y[r_k];
                        r_y2        <= r_tab_y[w_k_next];
                        r_x_out     <= w_x_out;
                        r_nan       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end else begin
                        r_k <= w_k_next;
                    end
                end
                OUT: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.x1        = r_x1;
    assign bus.x2        = r_x2;
    assign bus.y1        = r_y1;
    assign bus.y2        = r_y2;
    assign bus.x_out     = r_x_out;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.nan       = r_nan;
endmodule

// File: tb/tb_pwl_seg_select.sv
// tb_pwl_seg_select: directed spec cases plus randomized queries, checked every
// cycle against a real-arithmetic reference model of segment selection.
module tb_pwl_seg_select;
    localparam int NP = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwl_seg_select_if #(.S(32), .N_PTS(NP)) bus ();
    pwl_seg_select #(.S(32), .N_PTS(NP)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   n_chk  = 0;
    int   n_err  = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          cnt;   // edges after the start edge until out_valid rises
        logic        nan;
        logic [31:0] x1, x2, y1, y2, xo;
    } res_t;

    function automatic res_t zres();
        res_t r;
        r.cnt = 0; r.nan = 1'b0;
        r.x1 = '0; r.x2 = '0; r.y1 = '0; r.y2 = '0; r.xo = '0;
        return r;
    endfunction

    function automatic logic is_nan(input logic [31:0] b);
        return (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    endfunction

    function automatic real f2r(input logic [31:0] b);
        real m, v;
        int  e;
        e = int'(b[30:23]);
        m = real'(b[22:0]);
        if (e == 255)    v = 1.0e300;
        else if (e == 0) v = m * (2.0 ** (-149));
        else             v = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -v : v;
    endfunction

    function automatic res_t predict(input logic [31:0] tx_in [NP], input logic [31:0] ty_in [NP],
                                     input logic we, input int wa, input logic [31:0] wx,
                                     input logic [31:0] wy, input logic [31:0] q);
        logic [31:0] tx [NP];
        logic [31:0] ty [NP];
        res_t r;
        int   k;
        logic found;
        real  qr;
        tx = tx_in;
        ty = ty_in;
        if (we) begin tx[wa] = wx; ty[wa] = wy; end
        r = zres();
        if (is_nan(q)) begin
            r.cnt = 1;
            r.nan = 1'b1;
            return r;
        end
        qr = f2r(q);
        k = NP - 2;
        found = 1'b0;
        for (int i = 0; i < NP - 1; i++) begin
            if (!found && qr < f2r(tx[i+1])) begin k = i; found = 1'b1; end
        end
        r.cnt = k + 1;
        r.x1 = tx[k]; r.x2 = tx[k+1];
        r.y1 = ty[k]; r.y2 = ty[k+1];
        r.xo = q;
`ifdef PWL_CLAMP_EN
        if (qr < f2r(tx[0]))         r.xo = tx[0];
        else if (qr > f2r(tx[NP-1])) r.xo = tx[NP-1];
`endif
        return r;
    endfunction

    logic [31:0] m_tx [NP];
    logic [31:0] m_ty [NP];
    logic        m_busy = 1'b0;
    logic        m_vld  = 1'b0;
    int          m_el   = 0;
    res_t        m_pend;
    res_t        m_out;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_vld  <= 1'b0;
            m_el   <= 0;
            m_out  <= zres();
        end else if (m_vld) begin
            m_vld  <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            m_el <= m_el + 1;
            if (m_el + 1 == m_pend.cnt) begin
                m_vld <= 1'b1;
                m_out <= m_pend;
            end
        end else begin
            if (bus.tab_we) begin
                m_tx[bus.tab_addr] <= bus.tab_x;
                m_ty[bus.tab_addr] <= bus.tab_y;
            end
            if (bus.start) begin
                m_pend <= predict(m_tx, m_ty, bus.tab_we, int'(bus.tab_addr), bus.tab_x, bus.tab_y, bus.x);
                m_el   <= 0;
                m_busy <= 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
            chk("busy",      32'(bus.busy),      32'(m_busy));
            chk("nan",       32'(bus.nan),       32'(m_out.nan));
            chk("x1",        bus.x1,             m_out.x1);
            chk("x2",        bus.x2,             m_out.x2);
            chk("y1",        bus.y1,             m_out.y1);
            chk("y2",        bus.y2,             m_out.y2);
            chk("x_out",     bus.x_out,          m_out.xo);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_entry(input int a, input logic [31:0] wx, input logic [31:0] wy);
        bus.tab_we = 1'b1; bus.tab_addr = 3'(a); bus.tab_x = wx; bus.tab_y = wy;
        @(posedge clk); #1;
        bus.tab_we = 1'b0;
    endtask

    // Literal check of one query: out_valid cycle (start edge = edge 0) and data.
    task automatic run_query(input string nm, input logic [31:0] q, input int ecyc,
                             input logic [31:0] ex1, input logic [31:0] ex2,
                             input logic [31:0] ey1, input logic [31:0] ey2,
                             input logic [31:0] exo, input logic enan,
                             input logic we, input int wa, input logic [31:0] wx, input logic [31:0] wy);
        int   c;
        logic got;
        bus.start = 1'b1; bus.x = q;
        bus.tab_we = we; bus.tab_addr = 3'(wa); bus.tab_x = wx; bus.tab_y = wy;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.tab_we = 1'b0;
        c = 1; got = 1'b0;
        while (!got && c <= 20) begin
            @(negedge clk);
            if (bus.out_valid) got = 1'b1;
            else begin @(posedge clk); #1; c++; end
        end
        if (!got) begin
            n_chk++; n_err++;
            $display("FAIL %s timeout: no out_valid within 20 cycles, expected cycle %0d", nm, ecyc);
        end else begin
            chk({nm, ".cycle"}, 32'(c), 32'(ecyc));
            chk({nm, ".x1"}, bus.x1, ex1);
            chk({nm, ".x2"}, bus.x2, ex2);
            chk({nm, ".y1"}, bus.y1, ey1);
            chk({nm, ".y2"}, bus.y2, ey2);
            chk({nm, ".x_out"}, bus.x_out, exo);
            chk({nm, ".nan"}, 32'(bus.nan), 32'(enan));
        end
        @(posedge clk); #1;
    endtask

    localparam longint KR = 64'h41000000;   // table keys within +-8.0

    function automatic logic [31:0] key2bits(input longint k);
        if (k >= 0) return 32'(k);
        return {1'b1, 31'(-k)};
    endfunction

    task automatic rand_table(output logic [31:0] kx [NP], output logic [31:0] ky [NP]);
        longint k [NP];
        longint t;
        for (int i = 0; i < NP; i++) k[i] = longint'($urandom_range(0, 32'(2 * KR))) - KR;
        for (int i = 0; i < NP; i++)
            for (int j = 0; j < NP - 1 - i; j++)
                if (k[j] > k[j+1]) begin t = k[j]; k[j] = k[j+1]; k[j+1] = t; end
        for (int i = 1; i < NP; i++) if (k[i] <= k[i-1]) k[i] = k[i-1] + 1;
        for (int i = 0; i < NP; i++) begin kx[i] = key2bits(k[i]); ky[i] = $urandom; end
    endtask

    function automatic logic [31:0] pick_query();
        logic        s;
        logic [22:0] m;
        longint      k;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0, 1: return m_tx[$urandom_range(0, NP - 2)];
            2: begin
                m = 23'($urandom);
                if (m == 23'd0) m = 23'd1;
                return {s, 8'hff, m};
            end
            3: return {s, 31'd0};
            4: return {s, 8'hff, 23'd0};
            default: begin
                k = longint'($urandom_range(0, 32'(2 * (KR + KR / 4)))) - (KR + KR / 4);
                return key2bits(k);
            end
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] nx [NP];
        logic [31:0] ny [NP];
        logic [31:0] q;
        logic        we;
        int          rst_at, c, pulses;

        rst = 1'b1;
        bus.tab_we = 1'b0; bus.tab_addr = '0; bus.tab_x = '0; bus.tab_y = '0;
        bus.start = 1'b0; bus.x = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.nan", 32'(bus.nan), 32'd0);
        chk("rst.x1", bus.x1, 32'd0);
        chk("rst.x2", bus.x2, 32'd0);
        chk("rst.y1", bus.y1, 32'd0);
        chk("rst.y2", bus.y2, 32'd0);
        chk("rst.x_out", bus.x_out, 32'd0);
        chk_en = 1'b1;
        @(posedge clk); #1;

        write_entry(0, 32'hC0800000, 32'h00000000);
        write_entry(1, 32'hC0000000, 32'h3E000000);
        write_entry(2, 32'h00000000, 32'h3F000000);
        write_entry(3, 32'h40000000, 32'h3F600000);
        write_entry(4, 32'h40800000, 32'h3F800000);

        run_query("q_1p0", 32'h3F800000, 4, 32'h00000000, 32'h40000000, 32'h3F000000, 32'h3F600000,
                  32'h3F800000, 1'b0, 1'b0, 0, 0, 0);
        run_query("q_m2", 32'hC0000000, 3, 32'hC0000000, 32'h00000000, 32'h3E000000, 32'h3F000000,
                  32'hC0000000, 1'b0, 1'b0, 0, 0, 0);
        run_query("q_negzero", 32'h80000000, 4, 32'h00000000, 32'h40000000, 32'h3F000000, 32'h3F600000,
                  32'h80000000, 1'b0, 1'b0, 0, 0, 0);
`ifdef PWL_CLAMP_EN
        run_query("q_5p0", 32'h40A00000, 5, 32'h40000000, 32'h40800000, 32'h3F600000, 32'h3F800000,
                  32'h40800000, 1'b0, 1'b0, 0, 0, 0);
        run_query("q_m8", 32'hC1000000, 2, 32'hC0800000, 32'hC0000000, 32'h00000000, 32'h3E000000,
                  32'hC0800000, 1'b0, 1'b0, 0, 0, 0);
`else
        run_query("q_5p0", 32'h40A00000, 5, 32'h40000000, 32'h40800000, 32'h3F600000, 32'h3F800000,
                  32'h40A00000, 1'b0, 1'b0, 0, 0, 0);
        run_query("q_m8", 32'hC1000000, 2, 32'hC0800000, 32'hC0000000, 32'h00000000, 32'h3E000000,
                  32'hC1000000, 1'b0, 1'b0, 0, 0, 0);
`endif
        run_query("q_nan", 32'h7FC00000, 2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 0, 0, 0);

        // Abort: start at edge 0, ignored start + write in cycle 1, rst in cycle 2.
        bus.start = 1'b1; bus.x = 32'h40000000;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.x = 32'hC0800000;
        bus.tab_we = 1'b1; bus.tab_addr = 3'd2; bus.tab_x = 32'h12345678; bus.tab_y = 32'h9ABCDEF0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.tab_we = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort.busy", 32'(bus.busy), 32'd0);
        chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        chk("abort.pulses", 32'(pulses), 32'd0);
        @(posedge clk); #1;
        run_query("q_after_abort", 32'h3F800000, 4, 32'h00000000, 32'h40000000, 32'h3F000000, 32'h3F600000,
                  32'h3F800000, 1'b0, 1'b0, 0, 0, 0);

        // Write and start in the same cycle: scan must see the new entry 3.
        run_query("q_wr_start", 32'h3F000000, 4, 32'h00000000, 32'h3F800000, 32'h3F000000, 32'h3F400000,
                  32'h3F000000, 1'b0, 1'b1, 3, 32'h3F800000, 32'h3F400000);
        write_entry(3, 32'h40000000, 32'h3F600000);

        // Randomized queries, table reloads, busy-time noise and aborts.
        for (int t = 0; t < 250; t++) begin
            we = 1'b0;
            if (t % 6 == 0) begin
                rand_table(nx, ny);
                for (int i = 0; i < NP - 1; i++) write_entry(i, nx[i], ny[i]);
                we = 1'b1;
            end
            q = pick_query();
            bus.start = 1'b1; bus.x = q;
            bus.tab_we = we; bus.tab_addr = 3'(NP - 1); bus.tab_x = nx[NP-1]; bus.tab_y = ny[NP-1];
            @(posedge clk); #1;
            bus.start = 1'b0; bus.tab_we = 1'b0;
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
            c = 0;
            while (m_busy && c < 30) begin
                if (c == rst_at) rst = 1'b1;
                else if ($urandom_range(0, 3) == 0) begin
                    bus.start = 1'b1; bus.x = $urandom;
                    bus.tab_we = 1'b1; bus.tab_addr = 3'($urandom_range(0, NP - 1));
                    bus.tab_x = $urandom; bus.tab_y = $urandom;
                end
                @(posedge clk); #1;
                rst = 1'b0; bus.start = 1'b0; bus.tab_we = 1'b0;
                c++;
            end
            if (m_busy) begin
                n_chk++; n_err++;
                $display("FAIL rand_timeout: trial %0d still busy after 30 cycles, expected idle", t);
            end
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pwl_seg_select.md
PWL_SEG_SELECT -- requirements
Module: pwl_seg_select

Interface
- REQ-001: Parameter S, default 32: float width; IEEE-754 single only.
- REQ-002: Parameter N_PTS, default 16: breakpoint count, 3..64.
- REQ-003: clk  input  1: single clock; all logic on rising edge.
- REQ-004: rst  input  1: reset, synchronous, active-high.
- REQ-005: tab_we  input  1: table write strobe.
- REQ-006: tab_addr  input  $clog2(N_PTS): breakpoint index.
- REQ-007: tab_x, tab_y  input  S each: breakpoint abscissa and ordinate.
- REQ-008: start  input  1: one-cycle request; samples x.
- REQ-009: x  input  S: query value.
- REQ-010: x1, x2, y1, y2  output  S each: selected segment endpoints; these feed the downstream lerp stage.
- REQ-011: x_out  output  S: value the lerp stage evaluates.
- REQ-012: out_valid  output  1: one-cycle pulse; drives the lerp start input.
- REQ-013: busy  output  1: high in SCAN and OUT.
- REQ-014: nan  output  1: query was NaN; valid with out_valid.

Function
- REQ-015: The table SHALL hold N_PTS (x, y) register pairs, written on a clk edge with tab_we high in IDLE; writes SHALL be ignored while busy.
- REQ-016: The table SHALL be strictly ascending in x; software guarantees this and the block does not check it.
- REQ-017: FSM states SHALL be IDLE, SCAN and OUT: IDLE->SCAN on start; SCAN->OUT on hit or last index; OUT->IDLE after one cycle.
- REQ-018: start SHALL be ignored when busy; the latched query SHALL be unchanged.
- REQ-019: In SCAN, cycle k (k=0..N_PTS-2) SHALL test q < tab_x[k+1]; the first true test selects segment k, and k=N_PTS-2 is selected unconditionally.
- REQ-020: Float compare SHALL use sign-magnitude ordering, with -0 equal to +0; q == tab_x[k+1] SHALL select segment k+1.
- REQ-021: Latency: start is sampled at edge 0; segment k SHALL give out_valid high during cycle k+2.
- REQ-022: On segment k: x1=tab_x[k], x2=tab_x[k+1], y1=tab_y[k], y2=tab_y[k+1].
- REQ-023: Outputs SHALL hold stable from out_valid until the next accepted start.
- REQ-024: NaN query (exp all ones, mantissa nonzero) SHALL skip the scan: OUT on cycle 1, nan=1, x1/x2/y1/y2/x_out all 0.
- REQ-025: A query below tab_x[0] SHALL select segment 0 at cycle-2 out_valid.
- REQ-026: tab_we and start in the same IDLE cycle: the write SHALL commit at that edge and the scan SHALL use the updated table.

Reset
- REQ-027: rst SHALL force IDLE and clear all outputs to 0, including x1, x2, y1, y2, x_out, out_valid, busy and nan.
- REQ-028: The table contents SHALL be unaffected by rst.
- REQ-029: rst during SCAN or OUT SHALL abort the scan with no out_valid pulse, and the block SHALL be idle on the next cycle.

Configuration
- REQ-030: Macro PWL_CLAMP_EN SHALL control out-of-range handling.
- REQ-031: PWL_CLAMP_EN defined: q < tab_x[0] gives x_out=tab_x[0], and q > tab_x[N_PTS-1] gives x_out=tab_x[N_PTS-1]; otherwise x_out=q.
- REQ-032: PWL_CLAMP_EN undefined: x_out=q always, so the end segments extrapolate.
- REQ-033: Segment selection and latency SHALL be identical in both builds.

Verification
N_PTS=5, x = {C0800000, C0000000, 00000000, 40000000, 40800000}, y = {00000000, 3E000000, 3F000000, 3F600000, 3F800000}.
- REQ-034: x=3F800000 -> out_valid in cycle 4; x1=00000000, x2=40000000, y1=3F000000, y2=3F600000, x_out=3F800000.
- REQ-035: x=C0000000 -> segment 1 in cycle 3; x1=C0000000, y1=3E000000. x=80000000 (-0) -> segment 2.
- REQ-036: x=40A00000 -> segment 3 in cycle 5; x_out=40800000 with PWL_CLAMP_EN, 40A00000 without it.
- REQ-037: x=7FC00000 -> out_valid in cycle 2, nan=1, all data outputs 0.
- REQ-038: start x=40000000, rst in cycle 2 -> no out_valid, busy=0 in cycle 3; a second start pulsed in cycle 1 is ignored and the table is unchanged.
